// File: rtl/div_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential divider.
interface div_if #(
  parameter int LENin1 = 8,
  parameter int LENin2 = 8
);
  logic              start;
  logic [LENin1-1:0] in1;
  logic [LENin2-1:0] in2;
  logic              busy;
  logic              done;
  logic [LENin1-1:0] quo;
  logic [LENin2-1:0] rem;
  logic              dbz;

  modport master (output start, in1, in2, input busy, done, quo, rem, dbz);
  modport slave  (input start, in1, in2, output busy, done, quo, rem, dbz);
endinterface

// File: rtl/div.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Define DIV_DBZ_EN to finish a zero-divisor operation one cycle after the start and raise dbz.
module div #(
  parameter int LENin1 = 8,
  parameter int LENin2 = 8
) (
  input  logic clk,
  input  logic nrst,
  div_if.slave bus
);
  localparam int CW = $clog2(LENin1 + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [LENin1-1:0] dvd;        // shifts dividend bits out, quotient bits in
  logic [LENin2-1:0] dsr;
  logic [LENin2-1:0] part;
  logic [LENin1-1:0] quo_q;
  logic [LENin2-1:0] rem_q;
  logic [CW-1:0]     cnt;
  logic [LENin2:0]   shifted;
  logic [LENin2-1:0] part_nxt;
  logic [LENin1-1:0] dvd_nxt;
  logic              ge;
  logic              accept;
  logic              cnt_last;
  logic              fast_zero;
  logic              last;

  assign accept   = bus.start && (state != RUN);
  assign cnt_last = (cnt == CW'(1));

`ifdef DIV_DBZ_EN
  assign fast_zero = (dsr == '0);
`else
  assign fast_zero = 1'b0;
`endif

  assign last = cnt_last || fast_zero;

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // After a restoring step the partial remainder is below the divisor, so only the
  // shifted trial value needs the extra top bit.
  always_comb begin
    shifted  = {part, dvd[LENin1-1]};
    ge       = (shifted >= {1'b0, dsr});
    part_nxt = ge ? LENin2'(shifted - {1'b0, dsr}) : shifted[LENin2-1:0];
    dvd_nxt  = {dvd[LENin1-2:0], ge};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dvd   <= '0;
      dsr   <= '0;
      part  <= '0;
      cnt   <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else if (accept) begin
      dvd  <= bus.in1;
      dsr  <= bus.in2;
      part <= '0;
      cnt  <= CW'(LENin1);
    end else if (state == RUN) begin
      if (fast_zero) begin
        quo_q <= '1;
        rem_q <= LENin2'(dvd);
      end else begin
        // A zero divisor always subtracts, giving all-ones quotient and in1 as remainder.
        dvd  <= dvd_nxt;
        part <= part_nxt;
        cnt  <= cnt - CW'(1);
        if (cnt_last) begin
          quo_q <= dvd_nxt;
          rem_q <= part_nxt;
        end
      end
    end
  end

`ifdef DIV_DBZ_EN
  logic dbz_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                           dbz_q <= 1'b0;
    else if (accept)                     dbz_q <= 1'b0;
    else if ((state == RUN) && fast_zero) dbz_q <= 1'b1;
  end

  assign bus.dbz = dbz_q;
`else
  assign bus.dbz = 1'b0;
`endif

  assign bus.quo = quo_q;
  assign bus.rem = rem_q;
endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: table vectors, handshake corner cases and random
// operands on an 8/8 and a 2/3 instance, with results scoreboarded at each done.
module tb_div;
  logic clk = 1'b0;
  logic nrst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  div_if #(.LENin1(8), .LENin2(8)) b8 ();
  div_if #(.LENin1(2), .LENin2(3)) b2 ();

  div #(.LENin1(8), .LENin2(8)) u_div8 (.clk(clk), .nrst(nrst), .bus(b8.slave));
  div #(.LENin1(2), .LENin2(3)) u_div2 (.clk(clk), .nrst(nrst), .bus(b2.slave));

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp8_t;

  typedef struct {
    logic [1:0] q;
    logic [2:0] r;
    logic       z;
  } exp2_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    string      name;
  } vec_t;

  exp8_t q8[$];
  exp2_t q2[$];
  exp8_t m8;
  exp2_t m2;
  vec_t  vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: pop one expected result at every done pulse.
  always @(posedge clk) begin
    #1;
    if (nrst && b8.done) begin
      if (q8.size() == 0) check("d8 unexpected done", b8.done, 1'b0);
      else begin
        m8 = q8.pop_front();
        check("d8 quo", b8.quo, m8.q);
        check("d8 rem", b8.rem, m8.r);
        check("d8 dbz", b8.dbz, m8.z);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (nrst && b2.done) begin
      if (q2.size() == 0) check("d2 unexpected done", b2.done, 1'b0);
      else begin
        m2 = q2.pop_front();
        check("d2 quo", b2.quo, m2.q);
        check("d2 rem", b2.rem, m2.r);
        check("d2 dbz", b2.dbz, m2.z);
      end
    end
  end

  function automatic int lat_for(input logic zero, input int len1);
`ifdef DIV_DBZ_EN
    return zero ? 2 : len1 + 1;
`else
    return len1 + 1;
`endif
  endfunction

  // Called at posedge+1; returns at posedge+1 of the done cycle so a following call
  // issues its start during DONE (back-to-back).
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er, input string name);
    int    n;
    int    busyc;
    int    exp_lat;
    exp8_t e;
    e.q = eq;
    e.r = er;
`ifdef DIV_DBZ_EN
    e.z = (b == 8'd0);
`else
    e.z = 1'b0;
`endif
    exp_lat = lat_for(b == 8'd0, 8);
    b8.in1 = a;
    b8.in2 = b;
    b8.start = 1'b1;
    q8.push_back(e);
    @(posedge clk); #1;
    b8.start = 1'b0;
    b8.in1 = 8'($urandom);
    b8.in2 = 8'($urandom);
    n = 1;
    busyc = 0;
    while (!b8.done && n < 40) begin
      busyc += int'(b8.busy);
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, n, exp_lat);
    check({name, " busy cycles"}, busyc, exp_lat - 1);
  endtask

  task automatic run2(input logic [1:0] a, input logic [2:0] b);
    int    n;
    int    exp_lat;
    int    ai;
    int    bi;
    exp2_t e;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      e.q = 2'b11;
      e.r = {1'b0, a};
    end else begin
      e.q = 2'(ai / bi);
      e.r = 3'(ai % bi);
    end
`ifdef DIV_DBZ_EN
    e.z = (bi == 0);
`else
    e.z = 1'b0;
`endif
    exp_lat = lat_for(bi == 0, 2);
    b2.in1 = a;
    b2.in2 = b;
    b2.start = 1'b1;
    q2.push_back(e);
    @(posedge clk); #1;
    b2.start = 1'b0;
    n = 1;
    while (!b2.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("d2 latency", n, exp_lat);
  endtask

  initial begin
    int         n;
    int         dcount;
    logic [7:0] ra;
    logic [7:0] rb;
    exp8_t      e;

    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   "200/7"};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   "255/1"};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   "5/9"};
    vecs[3] = '{8'd100, 8'd0,   8'hFF,  8'd100, "100/0"};
    vecs[4] = '{8'd81,  8'd9,   8'd9,   8'd0,   "81/9"};
    vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,   "0/5"};
    vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   "255/255"};
    vecs[7] = '{8'd254, 8'd255, 8'd0,   8'd254, "254/255"};
    vecs[8] = '{8'd128, 8'd2,   8'd64,  8'd0,   "128/2"};
    vecs[9] = '{8'd1,   8'd0,   8'hFF,  8'd1,   "1/0"};

    nrst = 1'b0;
    b8.start = 1'b0; b8.in1 = '0; b8.in2 = '0;
    b2.start = 1'b0; b2.in1 = '0; b2.in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", b8.busy, 1'b0);
    check("reset done", b8.done, 1'b0);
    check("reset quo",  b8.quo,  8'd0);
    check("reset rem",  b8.rem,  8'd0);
    check("reset dbz",  b8.dbz,  1'b0);
    nrst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].name);

    // Results held through IDLE.
    run8(8'd200, 8'd7, 8'd28, 8'd4, "hold op");
    repeat (3) @(posedge clk);
    #1;
    check("idle busy", b8.busy, 1'b0);
    check("idle done", b8.done, 1'b0);
    check("idle quo",  b8.quo,  8'd28);
    check("idle rem",  b8.rem,  8'd4);

    // Start while busy is ignored; operands change mid-run; previous result held.
    run8(8'd81, 8'd9, 8'd9, 8'd0, "pre-ignore");
    e.q = 8'd28; e.r = 8'd4; e.z = 1'b0;
    b8.in1 = 8'd200; b8.in2 = 8'd7; b8.start = 1'b1;
    q8.push_back(e);
    @(posedge clk); #1;
    n = 1;
    for (int i = 0; i < 4; i++) begin
      b8.in1 = 8'd50 + 8'(i);
      b8.in2 = 8'd3;
      @(posedge clk); #1;
      n++;
      check("ignore busy", b8.busy, 1'b1);
    end
    check("run holds quo", b8.quo, 8'd9);
    check("run holds rem", b8.rem, 8'd0);
    b8.start = 1'b0;
    while (!b8.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("ignore latency", n, 9);
    @(posedge clk); #1;

    // Reset mid-run: everything clears at once, no done afterwards.
    e.q = 8'd28; e.r = 8'd4; e.z = 1'b0;
    b8.in1 = 8'd200; b8.in2 = 8'd7; b8.start = 1'b1;
    q8.push_back(e);
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check("mid-reset busy", b8.busy, 1'b0);
    check("mid-reset done", b8.done, 1'b0);
    check("mid-reset quo",  b8.quo,  8'd0);
    check("mid-reset rem",  b8.rem,  8'd0);
    check("mid-reset dbz",  b8.dbz,  1'b0);
    q8.delete();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      dcount += int'(b8.done);
    end
    check("no done after reset", dcount, 0);
    run8(8'd81, 8'd9, 8'd9, 8'd0, "post-reset 81/9");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = (i % 50 == 0) ? 8'd0 : 8'($urandom);
      if (rb == 8'd0) run8(ra, rb, 8'hFF, ra, "rand8");
      else            run8(ra, rb, ra / rb, ra % rb, "rand8");
    end

    for (int i = 0; i < 1000; i++)
      run2(2'($urandom), 3'($urandom));

    repeat (3) @(posedge clk);
    #1;
    check("d8 queue drained", q8.size(), 0);
    check("d2 queue drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
